// File: rtl/traffic_phase_controller_pkg.sv
// Shared types for the intersection phase controller: phase encoding, lamp
// patterns, duration width and the fixed phase-sequence helpers.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED1      = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED2      = 3'd5
    } phase_t;

    // Lamp heads are {red, yellow, green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef logic [6:0] dur_t;

    function automatic logic [2:0] ns_lamp(input phase_t p);
        logic [2:0] l;
        case (p)
            NS_GREEN:  l = LAMP_GRN;
            NS_YELLOW: l = LAMP_YEL;
            default:   l = LAMP_RED;
        endcase
        return l;
    endfunction

    function automatic logic [2:0] ew_lamp(input phase_t p);
        logic [2:0] l;
        case (p)
            EW_GREEN:  l = LAMP_GRN;
            EW_YELLOW: l = LAMP_YEL;
            default:   l = LAMP_RED;
        endcase
        return l;
    endfunction

    // Unconditional successor; the NS-green rest decision is layered on top
    function automatic phase_t phase_after(input phase_t p);
        phase_t n;
        case (p)
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = RED1;
            RED1:      n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            EW_YELLOW: n = RED2;
            default:   n = NS_GREEN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_phase_controller_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles; clr restarts
// the count so a new phase always begins on a fresh second.
module tick_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (clr || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-road intersection phase sequencer with per-phase countdown, load strobe
// for the countdown display, NS-green rest and a latched pedestrian request.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int GREEN_NS = 30,
    parameter int GREEN_EW = 25,
    parameter int YELLOW   = 4,
    parameter int ALL_RED  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_ew,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [6:0] remaining,
    output logic       load,
    output logic [2:0] phase,
    output logic       ped_ack
);

    generate
        if (TICK_DIV < 2 || GREEN_NS < 1 || GREEN_NS > 127 || GREEN_EW < 1 || GREEN_EW > 127 ||
            YELLOW < 1 || YELLOW > 127 || ALL_RED < 1 || ALL_RED > 127) begin : g_bad_param
            $error("traffic_phase_controller: parameter out of range");
        end
    endgenerate

    localparam dur_t DUR_NS  = dur_t'(GREEN_NS);
    localparam dur_t DUR_EW  = dur_t'(GREEN_EW);
    localparam dur_t DUR_YEL = dur_t'(YELLOW);
    localparam dur_t DUR_RED = dur_t'(ALL_RED);

    function automatic dur_t phase_dur(input phase_t p);
        dur_t d;
        case (p)
            NS_GREEN:             d = DUR_NS;
            EW_GREEN:             d = DUR_EW;
            NS_YELLOW, EW_YELLOW: d = DUR_YEL;
            default:              d = DUR_RED;
        endcase
        return d;
    endfunction

    phase_t     phase_q, phase_d;
    dur_t       remaining_q, remaining_d;
    logic [2:0] ns_light_q, ns_light_d;
    logic [2:0] ew_light_q, ew_light_d;
    logic       walk_q, walk_d;
    logic       load_q, load_d;
    logic       ped_pending_q, ped_pending_d;
    logic       ped_ack_q, ped_ack_d;

    logic       tick;
    logic       phase_end;
    phase_t     nxt_phase;
    logic       ped_clear;
    logic       ped_set;

    assign phase_end = tick && (remaining_q == 7'd1);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (phase_end),
        .tick(tick)
    );

    always_comb begin
        phase_d     = phase_q;
        remaining_d = remaining_q;
        ns_light_d  = ns_light_q;
        ew_light_d  = ew_light_q;
        walk_d      = walk_q;
        load_d      = 1'b0;

        // With no cross traffic and no waiting pedestrian, NS green rests
        nxt_phase = phase_after(phase_q);
        if (phase_q == NS_GREEN && !car_ew && !ped_pending_q) begin
            nxt_phase = NS_GREEN;
        end

        ped_clear = phase_end && (nxt_phase == EW_GREEN);
        ped_set   = ped_req && (!ped_pending_q || ped_clear);

        if (phase_end) begin
            phase_d     = nxt_phase;
            remaining_d = phase_dur(nxt_phase);
            ns_light_d  = ns_lamp(nxt_phase);
            ew_light_d  = ew_lamp(nxt_phase);
            walk_d      = (nxt_phase == EW_GREEN) ? ped_pending_q : 1'b0;
            load_d      = 1'b1;
        end else if (tick && remaining_q > 7'd1) begin
            remaining_d = remaining_q - 7'd1;
        end

        // A request arriving on the serving edge is kept for the next round
        ped_pending_d = ped_set || (ped_pending_q && !ped_clear);
        ped_ack_d     = ped_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= RED2;
            remaining_q   <= DUR_RED;
            ns_light_q    <= LAMP_RED;
            ew_light_q    <= LAMP_RED;
            walk_q        <= 1'b0;
            load_q        <= 1'b0;
            ped_pending_q <= 1'b0;
            ped_ack_q     <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            remaining_q   <= remaining_d;
            ns_light_q    <= ns_light_d;
            ew_light_q    <= ew_light_d;
            walk_q        <= walk_d;
            load_q        <= load_d;
            ped_pending_q <= ped_pending_d;
            ped_ack_q     <= ped_ack_d;
        end
    end

    assign ns_light  = ns_light_q;
    assign ew_light  = ew_light_q;
    assign walk      = walk_q;
    assign remaining = remaining_q;
    assign load      = load_q;
    assign phase     = phase_q;
    assign ped_ack   = ped_ack_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed-plus-random bench for traffic_phase_controller, checked every cycle
// against a time-in-phase reference model.
module tb_traffic_phase_controller;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       car_ew = 1'b1;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [6:0] remaining;
    logic       load;
    logic [2:0] phase;
    logic       ped_ack;

    traffic_phase_controller #(
        .TICK_DIV(TD),
        .GREEN_NS(3),
        .GREEN_EW(3),
        .YELLOW  (2),
        .ALL_RED (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .car_ew   (car_ew),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .remaining(remaining),
        .load     (load),
        .phase    (phase),
        .ped_ack  (ped_ack)
    );

    always #5 clk = ~clk;

    // Per-phase tables, index = phase code 0..5
    int dur_tab[6] = '{3, 2, 1, 3, 2, 1};
    int ns_tab[6]  = '{1, 2, 4, 4, 4, 4};
    int ew_tab[6]  = '{4, 4, 4, 1, 2, 4};

    int m_phase = 5;
    int m_t     = 0;
    bit m_pend  = 0;
    bit m_walk  = 0;
    bit m_load  = 0;
    bit m_ack   = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: a phase lasts dur*TD cycles; remaining = dur - elapsed/TD
    task automatic model_update();
        bit end_now;
        bit clear;
        bit pend_old;
        bit set;
        int nxt;
        if (rst) begin
            m_phase = 5; m_t = 0; m_pend = 0; m_walk = 0; m_load = 0; m_ack = 0;
            return;
        end
        pend_old = m_pend;
        end_now  = (m_t == dur_tab[m_phase] * TD - 1);
        clear    = 0;
        if (end_now) begin
            if (m_phase == 0 && !car_ew && !pend_old) nxt = 0;
            else nxt = (m_phase + 1) % 6;
            clear   = (nxt == 3);
            m_walk  = clear ? pend_old : 1'b0;
            m_phase = nxt;
            m_t     = 0;
            m_load  = 1;
        end else begin
            m_t++;
            m_load = 0;
        end
        set    = ped_req && (!pend_old || clear);
        m_ack  = set;
        m_pend = set || (pend_old && !clear);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        check("phase",     32'(phase),     32'(m_phase));
        check("ns_light",  32'(ns_light),  32'(ns_tab[m_phase]));
        check("ew_light",  32'(ew_light),  32'(ew_tab[m_phase]));
        check("remaining", 32'(remaining), 32'(dur_tab[m_phase] - m_t / TD));
        check("walk",      32'(walk),      32'(m_walk));
        check("load",      32'(load),      32'(m_load));
        check("ped_ack",   32'(ped_ack),   32'(m_ack));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_phase(input int p, input string tag);
        for (int i = 0; i < 200 && m_phase != p; i++) cycle();
        check(tag, 32'(phase), 32'(p));
    endtask

    initial begin
        // 1: reset, then full cycle with a car waiting
        rst = 1'b1; car_ew = 1'b1; ped_req = 1'b0;
        run(2);
        rst = 1'b0;
        run(60);

        // 2: no demand, NS green rests
        car_ew = 1'b0;
        run(60);

        // 3: single-cycle pedestrian pulse during NS green
        wait_phase(0, "reach_ns_green_3");
        run(2);
        ped_req = 1'b1; cycle(); ped_req = 1'b0;
        run(60);

        // 4: held request across the EW-green entry
        car_ew = 1'b0;
        wait_phase(0, "reach_ns_green_4");
        ped_req = 1'b1; run(20); ped_req = 1'b0;
        wait_phase(3, "reach_ew_green_4");
        ped_req = 1'b1; run(20); ped_req = 1'b0;
        run(60);

        // 5: reset mid EW_YELLOW with a pending request
        car_ew = 1'b1;
        wait_phase(3, "reach_ew_green_5");
        run(2);
        ped_req = 1'b1; cycle(); ped_req = 1'b0;
        wait_phase(4, "reach_ew_yellow_5");
        run(2);
        car_ew = 1'b0;
        rst = 1'b1; cycle(); rst = 1'b0;
        check("post_rst_phase", 32'(phase), 32'd5);
        check("post_rst_rem",   32'(remaining), 32'd1);
        run(40);

        // 6: car appears just after an NS terminal tick
        car_ew = 1'b0;
        wait_phase(0, "reach_ns_green_6");
        for (int i = 0; i < 200 && !(m_phase == 0 && m_t == 3 * TD - 1); i++) cycle();
        check("ns_terminal_6", 32'(remaining), 32'd1);
        cycle();
        car_ew = 1'b1;
        run(40);

        // Random traffic and requests with occasional resets
        for (int i = 0; i < 600; i++) begin
            if (i % 7 == 0) car_ew = ($urandom_range(0, 9) < 4);
            ped_req = ($urandom_range(0, 24) == 0);
            rst     = ($urandom_range(0, 249) == 0);
            cycle();
        end
        rst = 1'b0; ped_req = 1'b0;
        run(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
Phase sequencer for a two-road intersection: it drives the north-south and east-west lamp heads and a pedestrian walk signal. It is the initiator side of the countdown display path: on every phase entry it issues a `load` pulse together with the phase duration on `remaining`, then counts `remaining` down once per second. The seven-segment countdown display consumes `remaining`. A built-in prescaler derives the 1 s tick from `clk`; an east-west car sensor and a pedestrian request decide whether the cross phase is served.

Parameters:
- TICK_DIV, 50000000, `clk` cycles per 1 s tick (≥2).
- GREEN_NS, 30, north-south green duration in ticks (1..127).
- GREEN_EW, 25, east-west green duration in ticks (1..127).
- YELLOW, 4, yellow duration in ticks, both roads (1..127).
- ALL_RED, 2, all-red clearance duration in ticks (1..127).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- car_ew  in  1  east-west vehicle present (level).
- ped_req  in  1  pedestrian request (level or pulse).
- ns_light  out  3  {red,yellow,green}, one-hot.
- ew_light  out  3  {red,yellow,green}, one-hot.
- walk  out  1  pedestrian walk lamp.
- remaining  out  7  seconds left in the current phase (feeds the display `start_val`).
- load  out  1  one-cycle pulse on phase entry.
- phase  out  3  current phase encoding.
- ped_ack  out  1  one-cycle pulse when a request is latched.

Behaviour:
- Phase cycle: RED2 -> NS_GREEN -> NS_YELLOW -> RED1 -> EW_GREEN -> EW_YELLOW -> RED2. Encoding is 0..5 in that order, starting with NS_GREEN=0 and ending with RED2=5.
- Lamps per phase:
  - NS_GREEN: ns=001, ew=100.
  - NS_YELLOW: ns=010, ew=100.
  - RED1 / RED2: ns=100, ew=100.
  - EW_GREEN: ns=100, ew=001.
  - EW_YELLOW: ns=100, ew=010.
  - All outputs are registered.
- Reset values (cycle after `rst` sampled high): phase=RED2, ns=ew=100, walk=0, remaining=ALL_RED, load=0, ped_ack=0, prescaler=0, ped_pending=0. Reset mid-phase aborts immediately with no yellow.
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick` is asserted when count==TICK_DIV-1. The prescaler is cleared on every phase entry, so phase length is exactly duration*TICK_DIV cycles.
- Countdown:
  - On tick with remaining>1: remaining decrements.
  - On tick with remaining==1: phase ends. In the next cycle the new phase, lamps and remaining=new duration are updated together, and load=1 for exactly that cycle.
  - remaining never shows 0.
- Rest in NS green: at the end of NS_GREEN, if car_ew==0 and ped_pending==0, the block re-enters NS_GREEN. It reloads GREEN_NS and pulses load; lamps do not change.
  - The decision is sampled in the terminal tick cycle.
  - A car or request arriving later waits for the next terminal tick.
- Pedestrian handling:
  - ped_req high while ped_pending==0 sets ped_pending. ped_ack pulses one cycle later, once per latch, so a held request does not re-ack.
  - On EW_GREEN entry, ped_pending is captured into walk and then cleared. walk stays at its captured value for all of EW_GREEN and is 0 in every other phase.
  - If ped_req is high in the same cycle as the EW_GREEN-entry clear, set wins. The request is served on the next cycle round and ped_ack pulses.
- Widths: durations are compared and loaded as 7-bit unsigned. The prescaler width is $clog2(TICK_DIV). A parameter outside its range is an elaboration error.

Decomposition:
- Shared package `traffic_pkg` holds:
  - the phase enum (NS_GREEN..RED2);
  - lamp encodings LAMP_RED=100, LAMP_YEL=010, LAMP_GRN=001;
  - the 7-bit duration type.
- Sub-module `tick_prescaler` (params TICK_DIV; ports clk, rst, clr, tick) implements the 1 s divider with synchronous clear.
- The FSM, countdown and pedestrian latch are in the top level.

Test Plan:
All scenarios use TICK_DIV=4, GREEN_NS=3, GREEN_EW=3, YELLOW=2, ALL_RED=1.
1. Reset release, car_ew=1 -> RED2 lasts 4 cycles, then the phase sequence repeats with lengths 12, 8, 4, 12, 8, 4 cycles. Load pulses at each entry. remaining goes 3,2,1 in 4-cycle steps during green.
2. car_ew=0, ped_req=0 -> NS_GREEN repeats indefinitely with load every 12 cycles; ns_light stays 001 and no yellow ever appears.
3. car_ew=0, ped_req pulsed 1 cycle during NS_GREEN -> ped_ack one cycle later. At the end of green: NS_YELLOW, RED1, then EW_GREEN with walk=1 for all 12 cycles, followed by walk=0 in EW_YELLOW.
4. ped_req held high for 20 cycles starting in NS_GREEN -> exactly one ped_ack before EW_GREEN entry. A second ped_ack follows the entry clear, and walk=1 again on the next round.
5. rst asserted for 1 cycle mid-EW_YELLOW with ped_pending set -> next cycle phase=RED2, lamps 100/100, remaining=1, ped_pending=0, no load pulse. NS_GREEN is entered 4 cycles after rst deasserts.
6. car_ew rises 1 cycle after the NS_GREEN terminal tick -> NS_GREEN reloads once more (12 cycles), then NS_YELLOW follows.
